// File: rtl/health_ctrl.sv
// Per-player life manager: tracks lives, applies hit/heal, runs a frame-counted
// invulnerability window and drives the heart mask. Optional blink: HEALTH_BLINK_EN.
module health_ctrl #(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic       vsync,
  input  logic       hit,
  input  logic       heal,
  output logic [2:0] health_en,
  output logic       hit_ack,
  output logic       invuln,
  output logic       game_over,
  output logic [1:0] state_dbg
);

  localparam int HW = $clog2(MAX_HEALTH + 1);
  localparam int FW = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIVE  = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] health_q, health_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          vsync_d_q;
  logic          frame_tick;
  logic [2:0]    health_en_q, health_en_d;
  logic          hit_ack_q, hit_ack_d;
  logic          invuln_q, invuln_d;
  logic          game_over_q, game_over_d;
  logic          blank_d;
  logic          can_heal;

  assign frame_tick = vsync & ~vsync_d_q;
  assign can_heal   = heal && (health_q < HW'(MAX_HEALTH));

  // Handshake-free block: hit/heal are single-cycle requests sampled every clock;
  // hit_ack is the only response and pulses for exactly one cycle per accepted hit.
  always_comb begin
    state_d     = state_q;
    health_d    = health_q;
    frame_cnt_d = frame_cnt_q;
    hit_ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        health_d    = HW'(MAX_HEALTH);
        frame_cnt_d = '0;
        if (game_en) state_d = S_ALIVE;
      end
      S_ALIVE: begin
        if (hit) begin
          hit_ack_d = 1'b1;
          if (health_q > HW'(1)) begin
            health_d    = health_q - HW'(1);
            frame_cnt_d = FW'(INVULN_FRAMES);
            state_d     = S_INVULN;
          end else begin
            health_d = '0;
            state_d  = S_DEAD;
          end
        end else if (can_heal) begin
          health_d = health_q + HW'(1);
        end
      end
      S_INVULN: begin
        if (can_heal) health_d = health_q + HW'(1);
        if (frame_tick && (frame_cnt_q != '0)) begin
          frame_cnt_d = frame_cnt_q - FW'(1);
          if (frame_cnt_q == FW'(1)) state_d = S_ALIVE;
        end
      end
      default: ;
    endcase
    // Leaving the round wins over every same-cycle event.
    if (!game_en) begin
      state_d     = S_IDLE;
      health_d    = HW'(MAX_HEALTH);
      frame_cnt_d = '0;
      hit_ack_d   = 1'b0;
    end
    invuln_d    = (state_d == S_INVULN);
    game_over_d = (state_d == S_DEAD);
    // Thermometer mask: (1 << h) - 1 wraps to 3'b111 for h == 3 in 3 bits.
    if (state_d == S_IDLE || blank_d) health_en_d = 3'b000;
    else                              health_en_d = (3'b001 << health_d) - 3'b001;
  end

`ifdef HEALTH_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_q != S_INVULN || state_d != S_INVULN) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank_d = phase_d;
`else
  wire unused_blink_cfg = (BLINK_FRAMES != 0);
  assign blank_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      health_q    <= HW'(MAX_HEALTH);
      frame_cnt_q <= '0;
      vsync_d_q   <= 1'b0;
      health_en_q <= 3'b000;
      hit_ack_q   <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      health_q    <= health_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_d_q   <= vsync;
      health_en_q <= health_en_d;
      hit_ack_q   <= hit_ack_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign health_en = health_en_q;
  assign hit_ack   = hit_ack_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_health_ctrl.sv
// Bench for health_ctrl: expected {health_en, hit_ack, invuln, game_over} words are
// queued as stimulus is driven and popped when the DUT output is sampled.
module tb_health_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_en = 1'b0;
  logic       vsync = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic [2:0] health_en;
  logic       hit_ack;
  logic       invuln;
  logic       game_over;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;
  wire  [5:0] obs = {health_en, hit_ack, invuln, game_over};

  health_ctrl #(.MAX_HEALTH(3), .INVULN_FRAMES(120), .BLINK_FRAMES(8)) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .vsync(vsync), .hit(hit), .heal(heal),
    .health_en(health_en), .hit_ack(hit_ack), .invuln(invuln), .game_over(game_over),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic cyc(input logic g, input logic h, input logic he, input logic v);
    @(negedge clk);
    game_en = g; hit = h; heal = he; vsync = v;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    exp_q.push_back(6'b000_0_0_0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, exp_v); end
    total++;
    if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst = 1'b0;
    exp_q.push_back(6'b111_0_0_0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL start got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_hit_invuln;
    exp_q.push_back(6'b011_1_1_0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL first_hit got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b011_0_1_0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ack_one_cycle got=%b exp=%b", obs, exp_v); end
    frames(10);
    exp_q.push_back(6'b011_0_1_0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hit_ignored got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b011_0_1_0);
    frames(109);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL invuln_119 got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b011_0_0_0);
    frames(1);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL invuln_120 got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b001_1_1_0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL second_hit got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_heal;
    exp_q.push_back(6'b011_0_1_0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL heal_in_invuln got=%b exp=%b", obs, exp_v); end
    frames(120);
    exp_q.push_back(6'b111_0_0_0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL heal_to_max got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b111_0_0_0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL heal_saturate got=%b exp=%b", obs, exp_v); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    frames(119);
    exp_q.push_back(6'b011_0_0_0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hit_on_exit got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b001_1_1_0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hit_and_heal got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b001_0_0_0);
    frames(120);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL alive_at_one got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_death;
    exp_q.push_back(6'b000_1_0_1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fatal_hit got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b000_0_0_1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    frames(3);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL dead_sticky got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b000_0_0_0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL dead_to_idle got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b111_0_0_0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL restart got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_abort;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    frames(5);
    exp_q.push_back(6'b000_0_0_0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL abort_with_hit got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b111_0_0_0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL abort_restart got=%b exp=%b", obs, exp_v); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    frames(2);
    rst = 1'b1;
    exp_q.push_back(6'b000_0_0_0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_mid_invuln got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(6'b111_0_0_0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_restart got=%b exp=%b", obs, exp_v); end
  endtask

`ifdef HEALTH_BLINK_EN
  task automatic test_blink;
    logic [2:0] m;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 120; k++) begin
      m = (k == 120 || ((k / 8) % 2) == 0) ? 3'b011 : 3'b000;
      exp_q.push_back({m, 3'b000});
      frames(1);
      exp_v = exp_q.pop_front(); total++;
      if (health_en !== exp_v[5:3]) begin
        bad++; $display("FAIL blink_frame_%0d got=%b exp=%b", k, health_en, exp_v[5:3]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hit_invuln();
    test_heal();
    test_death();
    test_abort();
`ifdef HEALTH_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/health_ctrl.md
Name: health_ctrl

Overview:
Per-player life manager that drives the `health_en[2:0]` heart mask consumed by the health-drawing stage.
- Tracks remaining lives.
- Applies damage and heal events from game logic.
- Enforces a frame-counted invulnerability window after each hit.
- Declares game over.
- Sits between player/collision logic and the draw chain, one instance per player.

Parameters:
- MAX_HEALTH, 3, lives at game start and heal ceiling; legal range 1..3 because the mask is 3 bits.
- INVULN_FRAMES, 120, frames of invulnerability after an accepted hit; legal range ≥1.
- BLINK_FRAMES, 8, frames per blink half-period; used only with HEALTH_BLINK_EN.

Ports:
- clk  in  1  system clock, the same pixel clock as the draw chain.
- rst  in  1  synchronous, active-high reset.
- game_en  in  1  high while a game round is running.
- vsync  in  1  VGA vsync from the timing chain; its rising edge marks a frame tick.
- hit  in  1  single-cycle damage request.
- heal  in  1  single-cycle +1 life request.
- health_en  out  3  thermometer heart mask; bit i set means heart i is drawn.
- hit_ack  out  1  one-cycle pulse when a hit is accepted.
- invuln  out  1  high while invulnerable.
- game_over  out  1  high while the player is dead.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Registered outputs: every output is registered.
- Reset values: state=IDLE, health=MAX_HEALTH, health_en=3'b000, hit_ack=0, invuln=0, game_over=0, frame counter=0, vsync_d=0.
- Frame tick: `frame_tick = vsync & ~vsync_d`. vsync_d is registered every cycle, including in IDLE.
- Health register: width `$clog2(MAX_HEALTH+1)`. Mask encoding: 0→000, 1→001, 2→011, 3→111.
- Mask latency: health_en is registered from the next-state health, so it reflects a change one clock after the triggering input cycle.

State machine (IDLE, ALIVE, INVULN, DEAD):
- IDLE
  - health held at MAX_HEALTH; health_en=000; all flags 0.
  - game_en=1 → ALIVE; health_en becomes the mask of MAX_HEALTH on the next edge.
- ALIVE
  - hit=1 with health>1: health−1, hit_ack pulse, load frame counter=INVULN_FRAMES → INVULN; invuln=1 on the same edge.
  - hit=1 with health==1: health=0, hit_ack pulse → DEAD; game_over=1, health_en=000.
  - heal=1 with hit=0: health+1, saturating at MAX_HEALTH.
  - hit and heal in the same cycle: the hit is processed and the heal is dropped.
- INVULN
  - hit is ignored: no ack, no decrement.
  - heal is accepted as in ALIVE.
  - The frame counter decrements on each frame_tick.
  - frame_tick while counter==1 → ALIVE; the counter reaches 0 and invuln clears on that edge.
  - A hit arriving in the same cycle as that exit is ignored.
- DEAD
  - hit and heal are ignored; game_over=1, health_en=000.
  - Only exit is game_en=0.
- From any state, game_en=0 → IDLE on the next edge. This overrides hit, heal and frame_tick in the same cycle, and clears invuln and game_over.
- rst asserted in any state gives the reset values on the next edge, including mid-invulnerability.
- No counter wrap: the frame counter only decrements while nonzero.

Optional Feature:
HEALTH_BLINK_EN
- Defined:
  - A blink counter advances on frame_tick while in INVULN.
  - A phase bit toggles every BLINK_FRAMES frames, starting at 0 on INVULN entry.
  - While phase=1, health_en is forced to 000; otherwise it carries the normal mask.
  - On leaving INVULN the phase resets to 0 and the normal mask is restored on the same edge.
- Undefined: no blink logic is present and health_en always carries the mask of health.

Test Plan:
- Reset and start: rst for 2 cycles, then game_en=1 → health_en=111 one clock after game_en; invuln=0, game_over=0.
- Hit and invulnerability: single hit in ALIVE → hit_ack pulse, health_en=011, invuln=1; a second hit 10 frames later → no ack, health_en stays 011; after 120 vsync rising edges → invuln=0; a third hit → health_en=001.
- Death: three hits, each after invuln expires → third hit_ack, game_over=1, health_en=000; further hit or heal has no effect; game_en=0 → IDLE with all flags 0.
- Heal saturation and simultaneity: at health 3, heal → stays 111; at health 2, hit and heal in the same cycle → health_en=001, hit_ack=1.
- Abort: game_en=0 mid-INVULN in the same cycle as hit → IDLE, health_en=000, invuln=0, no hit_ack.
- HEALTH_BLINK_EN: BLINK_FRAMES=8 with a hit at health 3 → health_en alternates 011/000 every 8 frames for 120 frames, then steady 011.
